branch_predict_unit: RTL and testbench
======================================

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning the width of the program counter inputs.
REQ-002 SHALL have parameter IDX_W, default 4, meaning the table index width; the table depth is 2^IDX_W (IDX_W <= PC_W).
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-004 SHALL have parameter INIT_CTR, default 2'b01, meaning the reset value of every 2-bit counter (weakly not-taken).
REQ-005 SHALL have port clk  in  1  system clock; the block uses one clock; all state changes on the rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-007 SHALL have port if_pc  in  PC_W  fetch PC used for the lookup.
REQ-008 SHALL have port pred_taken  out  1  predicted direction for if_pc; combinational read.
REQ-009 SHALL have port ex_valid  in  1  the EX-stage instruction is valid.
REQ-010 SHALL have port ex_bran  in  1  the EX-stage instruction is a conditional branch.
REQ-011 SHALL have port ex_cond  in  3  condition code.
REQ-012 SHALL have port ex_flag  in  3  flags {Z,V,N}: bit2=Z, bit1=V, bit0=N.
REQ-013 SHALL have port ex_pc  in  PC_W  PC of the EX-stage instruction.
REQ-014 SHALL have port ex_pred  in  1  prediction carried with the EX-stage instruction.
REQ-015 SHALL have port flush  out  1  registered one-cycle mispredict pulse.
REQ-016 SHALL have port flush_taken  out  1  registered actual direction for the redirect; valid only while flush=1.
REQ-017 SHALL have port stat_clr  in  1  synchronous clear of the statistics counters.
REQ-018 SHALL have ports stat_bran and stat_misp  out  CNT_W each  resolved-branch count and mispredict count.

Function
REQ-019 SHALL evaluate cond_met per ex_cond: 0 Z; 1 !Z; 2 !Z&!N; 3 N; 4 Z|!N; 5 Z|N; 6 V; 7 always 1.
REQ-020 SHALL define the actual direction as taken = ex_valid & ex_bran & cond_met & !shadow.
REQ-021 SHALL define resolve = ex_valid & !shadow, and misp = resolve & (taken != ex_pred); a non-branch that carries ex_pred=1 therefore mispredicts.
REQ-022 SHALL register flush<=misp and flush_taken<=taken on each edge, giving 1-cycle latency from the resolving cycle.
REQ-023 SHALL define shadow = flush, so EX inputs in the cycle in which flush is high are ignored (wrong-path): no table update, no flush, no statistics change.
REQ-024 SHALL hold 2^IDX_W 2-bit saturating counters; pred_taken = counter[if_pc[IDX_W-1:0]][1].
REQ-025 SHALL, when resolve & ex_bran, update counter[ex_pc[IDX_W-1:0]]: +1 if taken, -1 if not, saturating at 2'b11 and 2'b00.
REQ-026 SHALL NOT update the table for non-branch instructions.
REQ-027 SHALL return the pre-update value on pred_taken when the lookup index and the update index are equal in the same cycle; the new value is visible from the next cycle.
REQ-028 SHALL increment stat_bran on each resolve & ex_bran, and increment stat_misp on each misp; both counters saturate at all-ones and never wrap.
REQ-029 SHALL give stat_clr priority over a same-cycle increment, so both counters read 0 on the next cycle.

Reset
REQ-030 SHALL, while rst_n=0, immediately force flush=0, flush_taken=0, stat_bran=0, stat_misp=0 and every counter to INIT_CTR, regardless of clk.
REQ-031 SHALL, on reset asserted mid-operation, discard any pending flush; the first edge after rst_n rises resolves normally, with shadow=0.

Verification
REQ-032 SHALL pass: after reset, if_pc=any -> pred_taken=0; ex_valid=1, ex_bran=1, ex_cond=7, ex_pred=0 -> next cycle flush=1, flush_taken=1, stat_bran=1, stat_misp=1.
REQ-033 SHALL pass a full cond truth table with ex_pred = the expected direction: cond0/Z=1->taken; cond2/N=1->not; cond4/flag 000->taken; cond5/flag 001->taken; cond6/V=1->taken; any flag with ex_bran=0 -> not taken; flush stays 0 throughout.
REQ-034 SHALL pass: three taken resolves at ex_pc=0x0013 -> counter at idx 3 reads 01->10->11->11 and pred_taken(if_pc=0x0003)=1 from the cycle after the first update.
REQ-035 SHALL pass: a mispredict with a different mispredicting instruction presented in the next cycle -> only one flush pulse; the second instruction causes no stat change.
REQ-036 SHALL pass: with IDX_W=2 and CNT_W=2, four mispredicts -> stat_misp=3 (saturated); stat_clr together with misp -> stat_misp=0 next cycle.
REQ-037 SHALL pass: rst_n=0 asserted between clock edges while flush=1 -> flush=0 immediately and all counters read INIT_CTR.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Direction predictor: 2-bit saturating counter table plus EX-stage resolution and statistics.
// Lookup is combinational; the flush pulse is registered (1 cycle); there is no backpressure.
module branch_predict_unit #(
   parameter int         PC_W     = 16,
   parameter int         IDX_W    = 4,
   parameter int         CNT_W    = 16,
   parameter logic [1:0] INIT_CTR = 2'b01
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  if_pc,
   output logic             pred_taken,
   input  logic             ex_valid,
   input  logic             ex_bran,
   input  logic [2:0]       ex_cond,
   input  logic [2:0]       ex_flag,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic             ex_pred,
   output logic             flush,
   output logic             flush_taken,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] stat_bran,
   output logic [CNT_W-1:0] stat_misp
);
   localparam int               DEPTH   = 1 << IDX_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       ctr_q [DEPTH];
   logic [1:0]       ctr_d;
   logic [1:0]       upd_cur;
   logic [IDX_W-1:0] upd_idx;
   logic             flush_q, flush_d;
   logic             flush_taken_q, flush_taken_d;
   logic [CNT_W-1:0] stat_bran_q, stat_bran_d;
   logic [CNT_W-1:0] stat_misp_q, stat_misp_d;
   logic             cond_met, shadow, taken, resolve, misp, upd_en;
   logic             flg_z, flg_v, flg_n;
   logic             unused_pc;

   assign flg_z = ex_flag[2];
   assign flg_v = ex_flag[1];
   assign flg_n = ex_flag[0];

   always_comb begin
      cond_met = 1'b0;
      case (ex_cond)
         3'd0:    cond_met = flg_z;
         3'd1:    cond_met = ~flg_z;
         3'd2:    cond_met = ~flg_z & ~flg_n;
         3'd3:    cond_met = flg_n;
         3'd4:    cond_met = flg_z | ~flg_n;
         3'd5:    cond_met = flg_z | flg_n;
         3'd6:    cond_met = flg_v;
         default: cond_met = 1'b1;
      endcase
   end

   // The cycle after a mispredict carries a wrong-path instruction; ignore it entirely.
   assign shadow  = flush_q;
   assign taken   = ex_valid & ex_bran & cond_met & ~shadow;
   assign resolve = ex_valid & ~shadow;
   assign misp    = resolve & (taken != ex_pred);
   assign upd_en  = resolve & ex_bran;

   assign upd_idx = ex_pc[IDX_W-1:0];
   assign upd_cur = ctr_q[upd_idx];

   always_comb begin
      ctr_d = upd_cur;
      if (taken) begin
         if (upd_cur != 2'b11) ctr_d = upd_cur + 2'b01;
      end else begin
         if (upd_cur != 2'b00) ctr_d = upd_cur - 2'b01;
      end
   end

   always_comb begin
      flush_d       = misp;
      flush_taken_d = taken;
      stat_bran_d   = stat_bran_q;
      stat_misp_d   = stat_misp_q;
      if (stat_clr) begin
         stat_bran_d = '0;
         stat_misp_d = '0;
      end else begin
         if (upd_en && !(&stat_bran_q)) stat_bran_d = stat_bran_q + CNT_ONE;
         if (misp && !(&stat_misp_q))   stat_misp_d = stat_misp_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) ctr_q[i] <= INIT_CTR;
      end else if (upd_en) begin
         ctr_q[upd_idx] <= ctr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_q       <= 1'b0;
         flush_taken_q <= 1'b0;
         stat_bran_q   <= '0;
         stat_misp_q   <= '0;
      end else begin
         flush_q       <= flush_d;
         flush_taken_q <= flush_taken_d;
         stat_bran_q   <= stat_bran_d;
         stat_misp_q   <= stat_misp_d;
      end
   end

   // Reading the table before the write lands gives the pre-update value on an index collision.
   assign pred_taken  = ctr_q[if_pc[IDX_W-1:0]][1];
   assign flush       = flush_q;
   assign flush_taken = flush_taken_q;
   assign stat_bran   = stat_bran_q;
   assign stat_misp   = stat_misp_q;

   assign unused_pc = ^{if_pc, ex_pc};
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: default instance plus a narrow IDX_W=2/CNT_W=2 instance.
module tb_branch_predict_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [15:0] if_pc = '0, ex_pc = '0;
   logic        ex_valid = 1'b0, ex_bran = 1'b0, ex_pred = 1'b0, stat_clr = 1'b0;
   logic [2:0]  ex_cond = '0, ex_flag = '0;
   logic        pred_taken, flush, flush_taken;
   logic [15:0] stat_bran, stat_misp;

   logic [15:0] s_if_pc = '0, s_ex_pc = '0;
   logic        s_ex_valid = 1'b0, s_ex_bran = 1'b0, s_ex_pred = 1'b0, s_stat_clr = 1'b0;
   logic [2:0]  s_ex_cond = 3'd7, s_ex_flag = '0;
   logic        s_pred_taken, s_flush, s_flush_taken;
   logic [1:0]  s_stat_bran, s_stat_misp;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predict_unit u_dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_bran(ex_bran), .ex_cond(ex_cond), .ex_flag(ex_flag),
      .ex_pc(ex_pc), .ex_pred(ex_pred), .flush(flush), .flush_taken(flush_taken),
      .stat_clr(stat_clr), .stat_bran(stat_bran), .stat_misp(stat_misp)
   );

   branch_predict_unit #(.PC_W(16), .IDX_W(2), .CNT_W(2), .INIT_CTR(2'b01)) u_small (
      .clk(clk), .rst_n(rst_n), .if_pc(s_if_pc), .pred_taken(s_pred_taken),
      .ex_valid(s_ex_valid), .ex_bran(s_ex_bran), .ex_cond(s_ex_cond), .ex_flag(s_ex_flag),
      .ex_pc(s_ex_pc), .ex_pred(s_ex_pred), .flush(s_flush), .flush_taken(s_flush_taken),
      .stat_clr(s_stat_clr), .stat_bran(s_stat_bran), .stat_misp(s_stat_misp)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic b, input logic [2:0] c,
                        input logic [2:0] f, input logic [15:0] pc, input logic p);
      ex_valid = v; ex_bran = b; ex_cond = c; ex_flag = f; ex_pc = pc; ex_pred = p;
   endtask

   task automatic idle();
      ex_valid = 1'b0; ex_bran = 1'b0; ex_pred = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL rst_flush got=%b exp=0", flush); end
      n_cmp++; if (flush_taken !== 1'b0) begin n_err++; $display("FAIL rst_flush_taken got=%b exp=0", flush_taken); end
      n_cmp++; if (stat_bran !== 16'd0) begin n_err++; $display("FAIL rst_stat_bran got=%0d exp=0", stat_bran); end
      n_cmp++; if (stat_misp !== 16'd0) begin n_err++; $display("FAIL rst_stat_misp got=%0d exp=0", stat_misp); end
      for (int i = 0; i < 16; i++) begin
         if_pc = 16'(i);
         #1;
         n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL rst_pred idx=%0d got=%b exp=0", i, pred_taken); end
      end
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_basic();
      if_pc = 16'h1234;
      drive(1'b1, 1'b1, 3'd7, 3'b000, 16'h0005, 1'b0);
      #1;
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL basic_pred got=%b exp=0", pred_taken); end
      step();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL basic_flush got=%b exp=1", flush); end
      n_cmp++; if (flush_taken !== 1'b1) begin n_err++; $display("FAIL basic_flush_taken got=%b exp=1", flush_taken); end
      n_cmp++; if (stat_bran !== 16'd1) begin n_err++; $display("FAIL basic_stat_bran got=%0d exp=1", stat_bran); end
      n_cmp++; if (stat_misp !== 16'd1) begin n_err++; $display("FAIL basic_stat_misp got=%0d exp=1", stat_misp); end
      idle();
      step();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL basic_flush_drop got=%b exp=0", flush); end
   endtask

   task automatic test_cond();
      logic [2:0] c_t [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd2};
      logic [2:0] f_t [9] = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b000, 3'b001, 3'b010, 3'b111, 3'b000};
      logic       b_t [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      logic       e_t [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, b_t[i], c_t[i], f_t[i], 16'h0008, e_t[i]);
         step();
         n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL cond_flush vec=%0d got=%b exp=0", i, flush); end
         n_cmp++; if (flush_taken !== e_t[i]) begin n_err++; $display("FAIL cond_dir vec=%0d got=%b exp=%b", i, flush_taken, e_t[i]); end
      end
      idle();
      n_cmp++; if (stat_bran !== 16'd9) begin n_err++; $display("FAIL cond_stat_bran got=%0d exp=9", stat_bran); end
      n_cmp++; if (stat_misp !== 16'd1) begin n_err++; $display("FAIL cond_stat_misp got=%0d exp=1", stat_misp); end
   endtask

   task automatic test_counter();
      logic exp_p [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      if_pc = 16'h0003;
      drive(1'b1, 1'b1, 3'd7, 3'b000, 16'h0013, 1'b1);
      #1;
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL ctr_pre_update got=%b exp=0", pred_taken); end
      for (int i = 0; i < 5; i++) begin
         if (i == 3) drive(1'b1, 1'b1, 3'd0, 3'b000, 16'h0013, 1'b0);
         step();
         n_cmp++; if (pred_taken !== exp_p[i]) begin n_err++; $display("FAIL ctr_pred step=%0d got=%b exp=%b", i, pred_taken, exp_p[i]); end
      end
      idle();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL ctr_flush got=%b exp=0", flush); end
      n_cmp++; if (stat_bran !== 16'd14) begin n_err++; $display("FAIL ctr_stat_bran got=%0d exp=14", stat_bran); end
   endtask

   task automatic test_back_to_back();
      if_pc = 16'h0003;
      drive(1'b1, 1'b0, 3'd7, 3'b000, 16'h0003, 1'b1);
      step();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL b2b_flush got=%b exp=1", flush); end
      n_cmp++; if (flush_taken !== 1'b0) begin n_err++; $display("FAIL b2b_flush_taken got=%b exp=0", flush_taken); end
      n_cmp++; if (stat_misp !== 16'd2) begin n_err++; $display("FAIL b2b_stat_misp got=%0d exp=2", stat_misp); end
      drive(1'b1, 1'b1, 3'd7, 3'b000, 16'h0003, 1'b0);
      step();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL b2b_shadow_flush got=%b exp=0", flush); end
      n_cmp++; if (stat_misp !== 16'd2) begin n_err++; $display("FAIL b2b_shadow_misp got=%0d exp=2", stat_misp); end
      n_cmp++; if (stat_bran !== 16'd14) begin n_err++; $display("FAIL b2b_shadow_bran got=%0d exp=14", stat_bran); end
      n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL b2b_shadow_table got=%b exp=0", pred_taken); end
      idle();
      step();
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL b2b_flush_end got=%b exp=0", flush); end
   endtask

   task automatic test_saturate();
      int exp_m;
      for (int k = 0; k < 4; k++) begin
         s_ex_valid = 1'b1; s_ex_bran = 1'b1; s_ex_cond = 3'd7; s_ex_pred = 1'b0;
         step();
         exp_m = (k + 1 > 3) ? 3 : k + 1;
         n_cmp++; if (s_flush !== 1'b1) begin n_err++; $display("FAIL sat_flush k=%0d got=%b exp=1", k, s_flush); end
         n_cmp++; if (s_stat_misp !== 2'(exp_m)) begin n_err++; $display("FAIL sat_misp k=%0d got=%0d exp=%0d", k, s_stat_misp, exp_m); end
         s_ex_valid = 1'b0;
         step();
      end
      n_cmp++; if (s_stat_bran !== 2'd3) begin n_err++; $display("FAIL sat_bran got=%0d exp=3", s_stat_bran); end
      s_ex_valid = 1'b1; s_stat_clr = 1'b1;
      step();
      n_cmp++; if (s_stat_misp !== 2'd0) begin n_err++; $display("FAIL clr_misp got=%0d exp=0", s_stat_misp); end
      n_cmp++; if (s_stat_bran !== 2'd0) begin n_err++; $display("FAIL clr_bran got=%0d exp=0", s_stat_bran); end
      n_cmp++; if (s_flush !== 1'b1) begin n_err++; $display("FAIL clr_flush got=%b exp=1", s_flush); end
      s_ex_valid = 1'b0; s_stat_clr = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      if_pc = 16'h0005;
      #1;
      n_cmp++; if (pred_taken !== 1'b1) begin n_err++; $display("FAIL mid_pred_before got=%b exp=1", pred_taken); end
      drive(1'b1, 1'b1, 3'd7, 3'b000, 16'h0007, 1'b0);
      step();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL mid_flush_before got=%b exp=1", flush); end
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (flush !== 1'b0) begin n_err++; $display("FAIL mid_flush got=%b exp=0", flush); end
      n_cmp++; if (flush_taken !== 1'b0) begin n_err++; $display("FAIL mid_flush_taken got=%b exp=0", flush_taken); end
      n_cmp++; if (stat_bran !== 16'd0) begin n_err++; $display("FAIL mid_stat_bran got=%0d exp=0", stat_bran); end
      n_cmp++; if (stat_misp !== 16'd0) begin n_err++; $display("FAIL mid_stat_misp got=%0d exp=0", stat_misp); end
      for (int i = 0; i < 16; i++) begin
         if_pc = 16'(i);
         #1;
         n_cmp++; if (pred_taken !== 1'b0) begin n_err++; $display("FAIL mid_pred idx=%0d got=%b exp=0", i, pred_taken); end
      end
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 3'd7, 3'b000, 16'h0007, 1'b0);
      step();
      n_cmp++; if (flush !== 1'b1) begin n_err++; $display("FAIL post_rst_flush got=%b exp=1", flush); end
      n_cmp++; if (stat_bran !== 16'd1) begin n_err++; $display("FAIL post_rst_bran got=%0d exp=1", stat_bran); end
      idle();
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cond();
      test_counter();
      test_back_to_back();
      test_saturate();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
